// File: rtl/smc_reg_router_pkg.sv
// Shared SMC register map, router FSM states and byte-index helper.
package smc_reg_router_pkg;

  localparam logic [7:0] SMC_REG_KBD_DATA = 8'h07;
  localparam logic [7:0] SMC_REG_KBD_STAT = 8'h18;
  localparam logic [7:0] SMC_REG_KBD_CMD  = 8'h19;
  localparam logic [7:0] SMC_REG_MS_DATA  = 8'h21;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_e;

  function automatic logic [2:0] bidx_inc(input logic [2:0] b);
    return (b == 3'd7) ? b : b + 3'd1;
  endfunction

endpackage

// File: rtl/smc_reg_router.sv
// SMC register-pointer decoder and PS/2 data router behind i2c_slave (address 0x42).
// Mouse FIFO routing on reg 0x21 is enabled by defining SMC_MOUSE_EN.
module smc_reg_router
  import smc_reg_router_pkg::*;
#(
  parameter logic [7:0] REG_DEFAULT = 8'h07,
  parameter logic [7:0] RD_FILL     = 8'h00
) (
  input  logic       clk6x,
  input  logic       reset,
  input  logic       devsel_i,
  input  logic       rw_bit_i,
  input  logic [7:0] rxbyte_i,
  input  logic       rxbyte_v_i,
  output logic [7:0] txbyte_o,
  input  logic       txbyte_deq_i,
  input  logic [7:0] kbd_data_i,
  input  logic       kbd_empty_i,
  output logic       kbd_deq_o,
  input  logic [7:0] kbd_stat_i,
  output logic [7:0] kbd_cmd_o,
  output logic       kbd_cmd_v_o,
  input  logic       kbd_busy_i,
  input  logic [7:0] ms_data_i,
  input  logic       ms_empty_i,
  output logic       ms_deq_o,
  output logic       cmd_drop_o
);

  state_e     state_q, state_d;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] regptr_q, regptr_d;
  logic       rw_q, rw_d;
  logic [7:0] txbyte_q, txbyte_d;
  logic [7:0] kbd_cmd_q, kbd_cmd_d;
  logic       kbd_cmd_v_q, kbd_cmd_v_d;
  logic       cmd_drop_q, cmd_drop_d;
  logic       kbd_deq_q, kbd_deq_d;
  logic [7:0] rd_sel;

`ifdef SMC_MOUSE_EN
  logic ms_deq_q, ms_deq_d;
  assign ms_deq_o = ms_deq_q;
`else
  logic unused_ms;
  assign unused_ms = ^{ms_data_i, ms_empty_i};
  assign ms_deq_o  = 1'b0;
`endif

  always_comb begin
    rd_sel = RD_FILL;
    case (regptr_q)
      SMC_REG_KBD_DATA: rd_sel = kbd_empty_i ? 8'h00 : kbd_data_i;
      SMC_REG_KBD_STAT: rd_sel = kbd_stat_i;
`ifdef SMC_MOUSE_EN
      SMC_REG_MS_DATA:  rd_sel = ms_empty_i ? 8'h00 : ms_data_i;
`endif
      default:          rd_sel = RD_FILL;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bidx_d      = bidx_q;
    regptr_d    = regptr_q;
    rw_d        = rw_bit_i;
    kbd_cmd_d   = kbd_cmd_q;
    kbd_cmd_v_d = 1'b0;
    cmd_drop_d  = 1'b0;
    kbd_deq_d   = 1'b0;
`ifdef SMC_MOUSE_EN
    ms_deq_d    = 1'b0;
`endif
    // Held during the dequeue cycle; the bidx bump then selects the next byte.
    txbyte_d = txbyte_deq_i ? txbyte_q : ((bidx_q == 3'd0) ? rd_sel : RD_FILL);

    if (state_q == ST_WR && rxbyte_v_i) begin
      if (bidx_q == 3'd0) begin
        regptr_d = rxbyte_i;
      end else if (bidx_q == 3'd1 && regptr_q == SMC_REG_KBD_CMD) begin
        if (kbd_busy_i) begin
          cmd_drop_d = 1'b1;
        end else begin
          kbd_cmd_d   = rxbyte_i;
          kbd_cmd_v_d = 1'b1;
        end
      end
      bidx_d = bidx_inc(bidx_q);
    end

    if (state_q == ST_RD && txbyte_deq_i) begin
      if (bidx_q == 3'd0) begin
        if (regptr_q == SMC_REG_KBD_DATA && !kbd_empty_i) kbd_deq_d = 1'b1;
`ifdef SMC_MOUSE_EN
        if (regptr_q == SMC_REG_MS_DATA && !ms_empty_i) ms_deq_d = 1'b1;
`endif
      end
      bidx_d = bidx_inc(bidx_q);
    end

    // Transfer boundaries override byte counting; a byte on the final cycle is still processed above.
    if (!devsel_i) begin
      state_d = ST_IDLE;
      bidx_d  = 3'd0;
    end else if (state_q == ST_IDLE || rw_bit_i != rw_q) begin
      state_d = rw_bit_i ? ST_RD : ST_WR;
      bidx_d  = 3'd0;
    end
  end

  always_ff @(posedge clk6x) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bidx_q      <= '0;
      regptr_q    <= REG_DEFAULT;
      rw_q        <= 1'b0;
      txbyte_q    <= RD_FILL;
      kbd_cmd_q   <= '0;
      kbd_cmd_v_q <= 1'b0;
      cmd_drop_q  <= 1'b0;
      kbd_deq_q   <= 1'b0;
`ifdef SMC_MOUSE_EN
      ms_deq_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bidx_q      <= bidx_d;
      regptr_q    <= regptr_d;
      rw_q        <= rw_d;
      txbyte_q    <= txbyte_d;
      kbd_cmd_q   <= kbd_cmd_d;
      kbd_cmd_v_q <= kbd_cmd_v_d;
      cmd_drop_q  <= cmd_drop_d;
      kbd_deq_q   <= kbd_deq_d;
`ifdef SMC_MOUSE_EN
      ms_deq_q    <= ms_deq_d;
`endif
    end
  end

  assign txbyte_o    = txbyte_q;
  assign kbd_cmd_o   = kbd_cmd_q;
  assign kbd_cmd_v_o = kbd_cmd_v_q;
  assign cmd_drop_o  = cmd_drop_q;
  assign kbd_deq_o   = kbd_deq_q;

endmodule

// File: tb/tb_smc_reg_router.sv
// Directed bench for smc_reg_router: read-byte scoreboard plus strobe pulse counting.
module tb_smc_reg_router;

  logic       clk6x = 1'b0;
  logic       reset;
  logic       devsel_i, rw_bit_i, rxbyte_v_i, txbyte_deq_i;
  logic [7:0] rxbyte_i, txbyte_o;
  logic [7:0] kbd_data_i, kbd_stat_i, kbd_cmd_o, ms_data_i;
  logic       kbd_empty_i, kbd_deq_o, kbd_cmd_v_o, kbd_busy_i;
  logic       ms_empty_i, ms_deq_o, cmd_drop_o;

  int vectors = 0;
  int miscompares = 0;
  int n_kbd_pop = 0, n_ms_pop = 0, n_cmd_v = 0, n_drop = 0;
  logic [7:0] last_cmd = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] cmd_q[$];

  always #10 clk6x = ~clk6x;

  smc_reg_router #(.REG_DEFAULT(8'h07), .RD_FILL(8'h00)) dut (
    .clk6x(clk6x), .reset(reset), .devsel_i(devsel_i), .rw_bit_i(rw_bit_i),
    .rxbyte_i(rxbyte_i), .rxbyte_v_i(rxbyte_v_i), .txbyte_o(txbyte_o),
    .txbyte_deq_i(txbyte_deq_i), .kbd_data_i(kbd_data_i), .kbd_empty_i(kbd_empty_i),
    .kbd_deq_o(kbd_deq_o), .kbd_stat_i(kbd_stat_i), .kbd_cmd_o(kbd_cmd_o),
    .kbd_cmd_v_o(kbd_cmd_v_o), .kbd_busy_i(kbd_busy_i), .ms_data_i(ms_data_i),
    .ms_empty_i(ms_empty_i), .ms_deq_o(ms_deq_o), .cmd_drop_o(cmd_drop_o)
  );

  always @(negedge clk6x) begin
    if (kbd_deq_o)   n_kbd_pop++;
    if (ms_deq_o)    n_ms_pop++;
    if (cmd_drop_o)  n_drop++;
    if (kbd_cmd_v_o) begin
      n_cmd_v++;
      last_cmd = kbd_cmd_o;
    end
  end

  task automatic tick();
    @(posedge clk6x);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] b);
    rxbyte_i   = b;
    rxbyte_v_i = 1'b1;
    tick();
    rxbyte_v_i = 1'b0;
    tick();
  endtask

  task automatic wr_xfer(input logic [7:0] ptr, input bit has_data, input logic [7:0] data);
    devsel_i = 1'b1;
    rw_bit_i = 1'b0;
    tick(); tick();
    wr_byte(ptr);
    if (has_data) wr_byte(data);
    devsel_i = 1'b0;
    tick(); tick();
  endtask

  task automatic rd_byte(input string tag);
    logic [7:0] obs, exp;
    tick(); tick(); tick();
    obs = txbyte_o;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, obs, exp);
    end
    txbyte_deq_i = 1'b1;
    tick();
    txbyte_deq_i = 1'b0;
    chk({tag, "_frozen"}, txbyte_o, obs);
  endtask

  task automatic rd_xfer(input string tag, input int n);
    devsel_i = 1'b1;
    rw_bit_i = 1'b1;
    tick(); tick();
    for (int i = 0; i < n; i++) rd_byte(tag);
    devsel_i = 1'b0;
    tick(); tick();
  endtask

  initial begin
    int p0, m0, c0, d0;
    logic [7:0] ce;
    reset = 1'b1;
    devsel_i = 1'b0; rw_bit_i = 1'b0; rxbyte_i = 8'h00; rxbyte_v_i = 1'b0;
    txbyte_deq_i = 1'b0; kbd_data_i = 8'h33; kbd_empty_i = 1'b0; kbd_stat_i = 8'hA5;
    kbd_busy_i = 1'b0; ms_data_i = 8'h08; ms_empty_i = 1'b0;
    tick(); tick(); tick();
    chk("rst_txbyte", txbyte_o, 8'h00);
    chk("rst_kbd_cmd", kbd_cmd_o, 8'h00);
    chk("rst_strobes", {kbd_deq_o, ms_deq_o, kbd_cmd_v_o, cmd_drop_o}, 4'b0000);
    reset = 1'b0;
    tick(); tick();

    // Read before any pointer write uses the default register.
    p0 = n_kbd_pop; exp_q.push_back(8'h33);
    rd_xfer("default_ptr", 1);
    chk("default_ptr_pops", n_kbd_pop - p0, 1);

    // 1: pointer write, stop, single read with data.
    kbd_data_i = 8'h1C;
    wr_xfer(8'h07, 1'b0, 8'h00);
    p0 = n_kbd_pop; exp_q.push_back(8'h1C);
    rd_xfer("t1_kbd", 1);
    chk("t1_pops", n_kbd_pop - p0, 1);

    // 2: empty keyboard FIFO.
    kbd_empty_i = 1'b1;
    p0 = n_kbd_pop; exp_q.push_back(8'h00);
    rd_xfer("t2_empty", 1);
    chk("t2_pops", n_kbd_pop - p0, 0);
    kbd_empty_i = 1'b0;

    // 3: command write, then same with host busy.
    c0 = n_cmd_v; d0 = n_drop; cmd_q.push_back(8'hED);
    wr_xfer(8'h19, 1'b1, 8'hED);
    chk("t3_cmd_v", n_cmd_v - c0, 1);
    chk("t3_drop", n_drop - d0, 0);
    ce = cmd_q.pop_front();
    chk("t3_cmd_strobed", last_cmd, ce);
    chk("t3_cmd_o", kbd_cmd_o, ce);
    kbd_busy_i = 1'b1;
    c0 = n_cmd_v; d0 = n_drop;
    wr_xfer(8'h19, 1'b1, 8'h5B);
    chk("t3b_cmd_v", n_cmd_v - c0, 0);
    chk("t3b_drop", n_drop - d0, 1);
    kbd_busy_i = 1'b0;

    // 4: pointer write, repeated start, 3-byte read.
    p0 = n_kbd_pop;
    exp_q.push_back(8'h1C); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    devsel_i = 1'b1; rw_bit_i = 1'b0;
    tick(); tick();
    wr_byte(8'h07);
    rd_xfer("t4_rs", 3);
    chk("t4_pops", n_kbd_pop - p0, 1);

    // Status register and an unmapped register.
    p0 = n_kbd_pop;
    wr_xfer(8'h18, 1'b0, 8'h00);
    exp_q.push_back(8'hA5);
    rd_xfer("stat", 1);
    wr_xfer(8'h55, 1'b0, 8'h00);
    exp_q.push_back(8'h00);
    rd_xfer("unknown", 1);
    chk("stat_unknown_pops", n_kbd_pop - p0, 0);

    // 5: mouse register.
    m0 = n_ms_pop; p0 = n_kbd_pop;
    wr_xfer(8'h21, 1'b0, 8'h00);
`ifdef SMC_MOUSE_EN
    exp_q.push_back(8'h08);
    rd_xfer("t5_ms", 1);
    chk("t5_ms_pops", n_ms_pop - m0, 1);
`else
    exp_q.push_back(8'h00);
    rd_xfer("t5_ms", 1);
    chk("t5_ms_pops", n_ms_pop - m0, 0);
`endif
    chk("t5_kbd_pops", n_kbd_pop - p0, 0);

    // 6: reset in the middle of a write after the pointer byte.
    devsel_i = 1'b1; rw_bit_i = 1'b0;
    tick(); tick();
    wr_byte(8'h21);
    reset = 1'b1;
    tick();
    chk("t6_txbyte", txbyte_o, 8'h00);
    chk("t6_kbd_cmd", kbd_cmd_o, 8'h00);
    chk("t6_strobes", {kbd_deq_o, ms_deq_o, kbd_cmd_v_o, cmd_drop_o}, 4'b0000);
    reset = 1'b0;
    devsel_i = 1'b0;
    tick(); tick();
    kbd_data_i = 8'h5A;
    p0 = n_kbd_pop; exp_q.push_back(8'h5A);
    rd_xfer("t6_after_rst", 1);
    chk("t6_pops", n_kbd_pop - p0, 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
